// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Brief    : UART receiver packing NUM_WORDS characters into one frame,
//            presented through a single valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int CLOCKS_PER_PULSE = 33,
    parameter int BITS_PER_WORD    = 8,
    parameter int NUM_WORDS        = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 rx,
    output logic [NUM_WORDS*BITS_PER_WORD-1:0]   m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 frame_err,
    output logic                                 overflow
);

    localparam int c_FW = NUM_WORDS * BITS_PER_WORD;
    localparam int c_CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int c_BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int c_WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [c_CW-1:0] c_CYC_LAST  = c_CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [c_CW-1:0] c_CYC_HALF  = c_CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(BITS_PER_WORD - 1);
    localparam logic [c_WW-1:0] c_WORD_LAST = c_WW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic                     r_sync1;
    logic                     r_sync2;
    logic [c_CW-1:0]          r_cyc;
    logic [c_CW-1:0]          w_cyc_nx;
    logic [c_BW-1:0]          r_bit;
    logic [c_BW-1:0]          w_bit_nx;
    logic                     w_shift_en;
    logic                     w_stop_good;
    logic                     w_stop_bad;
    logic [BITS_PER_WORD-1:0] r_shift;
    logic [c_WW-1:0]          r_word_cnt;
    logic [c_FW-1:0]          r_asm;
    logic [c_FW-1:0]          w_asm_nx;
    logic                     w_frame_done;
    logic                     w_out_free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cyc   <= w_cyc_nx;
            r_bit   <= w_bit_nx;
        end
    end

    // Sampling is purely counter-driven once a start is seen, so edges on
    // the line mid-character never restart it.
    always_comb begin
        w_state_nx  = r_state;
        w_cyc_nx    = r_cyc + 1'b1;
        w_bit_nx    = r_bit;
        w_shift_en  = 1'b0;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cyc_nx = '0;
                if (!r_sync2) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (r_cyc == c_CYC_HALF) begin
                    w_cyc_nx   = '0;
                    w_state_nx = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cyc == c_CYC_LAST) begin
                    w_cyc_nx   = '0;
                    w_shift_en = 1'b1;
                    if (r_bit == c_BIT_LAST) begin
                        w_bit_nx   = '0;
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_nx = r_bit + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (r_cyc == c_CYC_LAST) begin
                    w_cyc_nx    = '0;
                    w_state_nx  = S_IDLE;
                    w_stop_good = r_sync2;
                    w_stop_bad  = ~r_sync2;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Assembly register with the just-received character dropped into its slot.
    always_comb begin
        w_asm_nx = r_asm;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (r_word_cnt == c_WW'(i)) begin
                w_asm_nx[i*BITS_PER_WORD +: BITS_PER_WORD] = r_shift;
            end
        end
    end

    assign w_frame_done = w_stop_good && (r_word_cnt == c_WORD_LAST);
    assign w_out_free   = ~m_valid | m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift    <= '0;
            r_word_cnt <= '0;
            r_asm      <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err <= w_stop_bad;
            overflow  <= w_frame_done & ~w_out_free;

            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[BITS_PER_WORD-1:1]};
            end

            if (w_stop_bad) begin
                r_word_cnt <= '0;
            end else if (w_stop_good) begin
                r_asm      <= w_asm_nx;
                r_word_cnt <= w_frame_done ? '0 : r_word_cnt + 1'b1;
            end

            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (w_frame_done && w_out_free) begin
                m_data  <= w_asm_nx;
                m_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
